// File: rtl/idt_cfg_ctrl.sv
// Serial programmer for the IDT pixel-clock synthesizer: shifts a 24-bit word MSB-first,
// pulses the load strobe, then waits out the PLL lock interval before reporting locked.
module idt_cfg_ctrl #(
    parameter int unsigned CLK_DIV     = 2,
    parameter int unsigned LOCK_CYCLES = 100000,
    parameter bit          AUTO_START  = 1'b1,
    parameter logic [23:0] CFG_DEFAULT = 24'h31149F
) (
    input  logic        osc_clk,
    input  logic        osc_reset,
    input  logic        cfg_valid,
    input  logic [23:0] cfg_data,
    output logic        cfg_ready,
    output logic        idt_sclk,
    output logic        idt_data,
    output logic        idt_strobe,
    output logic        busy,
    output logic        locked
);
    localparam int DW = $clog2(CLK_DIV + 1);
    localparam int LW = $clog2(LOCK_CYCLES + 1);
    localparam logic [DW-1:0] DIV_LOAD  = DW'(CLK_DIV - 1);
    localparam logic [LW-1:0] LOCK_LOAD = LW'(LOCK_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, SHIFT_LO, SHIFT_HI, STROBE, LOCK_WAIT} state_e;

    state_e        state_q, state_d;
    logic [23:0]   shreg_q, shreg_d;
    logic [4:0]    bit_q, bit_d;
    logic [DW-1:0] div_q, div_d;
    logic [LW-1:0] lock_q, lock_d;
    logic          start_q, done_q, done_d, accept;
    logic          sclk_q, sclk_d, data_q, data_d, strobe_q, strobe_d;
    logic          ready_q, ready_d, busy_q, busy_d, locked_q, locked_d;

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        bit_d   = bit_q;
        div_d   = div_q;
        lock_d  = lock_q;
        done_d  = 1'b0;
        // The auto-start word is taken on the first edge out of reset, while ready is still low.
        accept  = (state_q == IDLE) && (start_q || (cfg_valid && ready_q));
        unique case (state_q)
            IDLE: if (accept) begin
                state_d = SHIFT_LO;
                shreg_d = start_q ? CFG_DEFAULT : cfg_data;
                bit_d   = 5'd23;
                div_d   = DIV_LOAD;
            end
            SHIFT_LO: if (div_q == '0) begin
                state_d = SHIFT_HI;
                div_d   = DIV_LOAD;
            end else div_d = div_q - 1'b1;
            SHIFT_HI: if (div_q == '0) begin
                div_d = DIV_LOAD;
                if (bit_q == 5'd0) state_d = STROBE;
                else begin
                    state_d = SHIFT_LO;
                    shreg_d = {shreg_q[22:0], 1'b0};
                    bit_d   = bit_q - 5'd1;
                end
            end else div_d = div_q - 1'b1;
            STROBE: if (div_q == '0) begin
                state_d = LOCK_WAIT;
                lock_d  = LOCK_LOAD;
            end else div_d = div_q - 1'b1;
            LOCK_WAIT: if (lock_q == '0) begin
                state_d = IDLE;
                done_d  = 1'b1;
            end else lock_d = lock_q - 1'b1;
            default: state_d = IDLE;
        endcase

        // Pins follow the state one edge later; ready/busy/locked react to acceptance at once.
        sclk_d   = (state_q == SHIFT_HI);
        data_d   = ((state_q == SHIFT_LO) || (state_q == SHIFT_HI)) && shreg_q[23];
        strobe_d = (state_q == STROBE);
        ready_d  = (state_q == IDLE) && !accept;
        busy_d   = (state_q != IDLE) || accept;
        locked_d = accept ? 1'b0 : (done_q | locked_q);
    end

    always_ff @(posedge osc_clk) begin
        if (osc_reset) begin
            state_q  <= IDLE;
            shreg_q  <= '0;
            bit_q    <= '0;
            div_q    <= '0;
            lock_q   <= '0;
            start_q  <= AUTO_START;
            done_q   <= 1'b0;
            sclk_q   <= 1'b0;
            data_q   <= 1'b0;
            strobe_q <= 1'b0;
            ready_q  <= 1'b0;
            busy_q   <= 1'b1;
            locked_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            shreg_q  <= shreg_d;
            bit_q    <= bit_d;
            div_q    <= div_d;
            lock_q   <= lock_d;
            start_q  <= 1'b0;
            done_q   <= done_d;
            sclk_q   <= sclk_d;
            data_q   <= data_d;
            strobe_q <= strobe_d;
            ready_q  <= ready_d;
            busy_q   <= busy_d;
            locked_q <= locked_d;
        end
    end

    assign cfg_ready  = ready_q;
    assign idt_sclk   = sclk_q;
    assign idt_data   = data_q;
    assign idt_strobe = strobe_q;
    assign busy       = busy_q;
    assign locked     = locked_q;
endmodule
